// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, funct, ALU and select encodings plus FSM states for the multicycle MIPS control.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
    S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11
  } state_t;
  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_FN} alu_cls_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-to-datapath bundle; master is the control FSM, slave the datapath.
interface multicycle_control_if #(parameter int OPW = 6, parameter int STW = 4);
  logic [OPW-1:0] opcode;
  logic [OPW-1:0] funct;
  logic zero;
  logic mem_ready;
  logic [1:0] alu_load;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic pc_en;
  logic iord;
  logic mem_write;
  logic ir_write;
  logic reg_write;
  logic reg_dst;
  logic mem_to_reg;
  logic illegal;
  logic [STW-1:0] state;
  modport master (
    input opcode, funct, zero, mem_ready,
    output alu_load, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
    ir_write, reg_write, reg_dst, mem_to_reg, illegal, state
  );
  modport slave (
    output opcode, funct, zero, mem_ready,
    input alu_load, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
    ir_write, reg_write, reg_dst, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: selects the ALU op from the state class (fixed add/sub or funct-driven) and flags unsupported funct.
module alu_decoder
  import mips_pkg::*;
#(parameter int OPW = 6) (
  input  logic [OPW-1:0] funct,
  input  alu_cls_t       cls,
  output logic [1:0]     alu_load,
  output logic           bad_funct
);
  logic [1:0] fn_op;
  always_comb begin
    fn_op = funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND : funct == FN_OR ? ALU_OR : ALU_ADD;
    bad_funct = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR});
    alu_load = cls == CLS_FN ? fn_op : cls == CLS_SUB ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
module multicycle_control
  import mips_pkg::*;
#(parameter int OPW = 6, parameter int STW = 4) (
  input logic clk,
  input logic rst,
  multicycle_control_if.master bus
);
  state_t cur, nxt;
  alu_cls_t cls;
  logic bad_funct, pc_en, ir_write, reg_write, mem_write, illegal;
  alu_decoder #(.OPW(OPW)) u_dec (.funct(bus.funct), .cls(cls), .alu_load(bus.alu_load), .bad_funct(bad_funct));
  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= S_FETCH;
    else cur <= nxt;
  always_comb begin
    nxt = S_FETCH;
    cls = CLS_ADD;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = SRCB_B;
    bus.pc_src = PC_ALU;
    bus.iord = 1'b0;
    bus.reg_dst = 1'b0;
    bus.mem_to_reg = 1'b0;
    pc_en = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    illegal = 1'b0;
    case (cur)
      S_FETCH: begin
        bus.alu_src_b = SRCB_4;
        ir_write = bus.mem_ready;
        pc_en = bus.mem_ready;
        nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM4;
        nxt = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
              bus.opcode == OP_RTYPE ? (bad_funct ? S_FETCH : S_EXEC) :
              bus.opcode == OP_BEQ ? S_BRANCH : bus.opcode == OP_ADDI ? S_ADDIEX :
              bus.opcode == OP_J ? S_JUMP : S_FETCH;
        illegal = nxt == S_FETCH;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        nxt = bus.opcode == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        bus.iord = 1'b1;
        mem_write = 1'b1;
        nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        cls = CLS_FN;
        nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        cls = CLS_SUB;
        bus.pc_src = PC_ALUOUT;
        pc_en = bus.zero;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        nxt = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        bus.pc_src = PC_JUMP;
        pc_en = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end
  // Reset holds the state in FETCH, whose enables follow mem_ready, so gate them directly.
  assign bus.pc_en = pc_en & ~rst;
  assign bus.ir_write = ir_write & ~rst;
  assign bus.reg_write = reg_write & ~rst;
  assign bus.mem_write = mem_write & ~rst;
  assign bus.illegal = illegal & ~rst;
  assign bus.state = STW'(cur);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction expected cycle traces checked against the control FSM.
module tb_multicycle_control;
  import mips_pkg::*;
  typedef struct packed {logic mr; logic [18:0] v;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ent_t tr[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [18:0] seen;
  logic [5:0] ops[6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  logic [5:0] fns[4] = '{FN_ADD, FN_SUB, FN_AND, FN_OR};
  always #5 clk = ~clk;
  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .rst(rst), .bus(bus));
  assign seen = {bus.state, bus.alu_load, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.pc_en, bus.iord,
                 bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask
  function automatic logic [18:0] ev(input logic [3:0] st, input logic [1:0] alu, input logic a,
      input logic [1:0] b, input logic [1:0] pc, input logic pe, input logic io, input logic mw,
      input logic iw, input logic rw, input logic rd, input logic m2r, input logic il);
    return {st, alu, a, b, pc, pe, io, mw, iw, rw, rd, m2r, il};
  endfunction
  function automatic logic rnd();
    return 1'($urandom);
  endfunction
  task automatic add(input logic mr, input logic [18:0] v);
    tr.push_back({mr, v});
  endtask
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int wf, input int wm);
    bit rleg;
    bit ill;
    logic [1:0] fa;
    rleg = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR};
    ill = !(op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J} || (op == OP_RTYPE && rleg));
    fa = fn == FN_SUB ? 2'd1 : fn == FN_AND ? 2'd2 : fn == FN_OR ? 2'd3 : 2'd0;
    tr.delete();
    repeat (wf) add(1'b0, ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1'b1, ev(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    add(rnd(), ev(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, ill));
    if (op == OP_LW || op == OP_SW) begin
      add(rnd(), ev(2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (wm) add(1'b0, op == OP_LW ? ev(3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0) : ev(5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      add(1'b1, op == OP_LW ? ev(3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0) : ev(5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      if (op == OP_LW) add(rnd(), ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    end else if (op == OP_RTYPE && rleg) begin
      add(rnd(), ev(6, fa, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(rnd(), ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    end else if (op == OP_BEQ) begin
      add(rnd(), ev(8, 1, 1, 0, 1, z, 0, 0, 0, 0, 0, 0, 0));
    end else if (op == OP_ADDI) begin
      add(rnd(), ev(9, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(rnd(), ev(10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    end else if (op == OP_J) begin
      add(rnd(), ev(11, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask
  task automatic run(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = tr[i].mr;
      @(negedge clk);
      check($sformatf("%s c%0d", name, i), 32'(seen), 32'(tr[i].v));
      @(posedge clk);
      #1;
    end
  endtask
  task automatic instr(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z, input int wf, input int wm);
    bus.opcode = op;
    bus.funct = fn;
    bus.zero = z;
    build(op, fn, z, wf, wm);
    run(name, tr.size());
  endtask
  task automatic reset_pulse(input string name);
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    check(name, 32'(seen), 32'(ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [5:0] op, fn;
    bus.opcode = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    reset_pulse("rst_init");
    instr("rsub", OP_RTYPE, FN_SUB, 1'b0, 0, 0);
    instr("lw_w2", OP_LW, 6'd0, 1'b0, 2, 2);
    instr("sw_w1", OP_SW, 6'd0, 1'b0, 1, 1);
    instr("beq_z1", OP_BEQ, 6'd0, 1'b1, 0, 0);
    instr("beq_z0", OP_BEQ, 6'd0, 1'b0, 0, 0);
    instr("j", OP_J, 6'd0, 1'b0, 0, 0);
    instr("addi", OP_ADDI, 6'd0, 1'b0, 0, 0);
    instr("ill_op", 6'b111111, 6'd0, 1'b0, 0, 0);
    instr("ill_fn", OP_RTYPE, 6'b101010, 1'b0, 0, 0);
    bus.opcode = OP_LW;
    build(OP_LW, 6'd0, 1'b0, 0, 3);
    run("lw_abort", 5);
    reset_pulse("rst_memrd");
    instr("after_rst", OP_RTYPE, FN_OR, 1'b0, 0, 0);
    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(0, 7) == 7 ? 6'($urandom) : ops[$urandom_range(0, 5)];
      fn = $urandom_range(0, 3) == 0 ? 6'($urandom) : fns[$urandom_range(0, 3)];
      instr($sformatf("rnd%0d", k), op, fn, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multicycle MIPS datapath. Sits directly upstream of the ALU.
- Sequences fetch/decode/execute/memory/writeback for the supported instruction subset.
- Drives the ALU 2-bit operation select and its operand muxes, and consumes the ALU zero flag for beq.
- Also generates PC, IR, register-file and memory enables, and handshakes with memory through mem_ready.

Parameters:
- OPW, 6, opcode and funct field width
- STW, 4, state register width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (sub result == 0)
- mem_ready  in  1  memory access completes this cycle
- alu_load  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
- pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- pc_en  out  1  PC load enable
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct
- state  out  4  current state, for debug

Behaviour:
- Reset is asynchronous and active-high.
  - While rst = 1: state = FETCH (0); all enables (pc_en, ir_write, reg_write, mem_write) and illegal = 0.
  - The first fetch begins on the first clk edge after rst deasserts.
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
  - Codes 12–15 are unreachable; they go to FETCH on the next edge with all enables 0.
- Outputs are Moore-style, decoded from state. Exceptions: pc_en in BRANCH and the mem_ready gating below.
- Outputs not listed for a state are 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_load=00, pc_src=00.
  - ir_write = pc_en = mem_ready.
  - Hold in FETCH while mem_ready=0, so PC+4 is applied exactly once.
  - On mem_ready go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_load=00 (branch target precompute). Next state by opcode:
  - 100011 lw and 101011 sw -> MEMADR
  - 000000 R-type -> EXEC
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - other -> FETCH, with illegal = 1
  - R-type funct not in {100000, 100010, 100100, 100101} -> FETCH, with illegal = 1
- MEMADR: alu_src_a=1, alu_src_b=10, alu_load=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEMWR: iord=1, mem_write=1 (held while waiting). Hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. alu_load from funct: 100000->00, 100010->01, 100100->10, 100101->11. Next ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_load=01, pc_src=01, pc_en=zero. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_load=00. Next ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- JUMP: pc_src=10, pc_en=1. Next FETCH.
- Cycle counts with mem_ready tied high:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
  - Each memory wait cycle adds 1.
- Reset mid-instruction: immediate return to FETCH. No write enable may glitch high during reset.
- Invariant: at most one of reg_write / mem_write / ir_write is high in any cycle.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR)
  - ALU op constants (ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_OR=11)
  - state encodings, and the alu_src_b / pc_src select encodings
- One sub-module, alu_decoder, is natural: maps funct plus a state-class select to alu_load and flags unsupported funct. It is reused by EXEC and DECODE.

Test Plan:
- Reset: assert rst mid-MEMRD -> state=0, pc_en=ir_write=reg_write=mem_write=0 immediately (asynchronous). After release with mem_ready=1 -> FETCH pulses ir_write=pc_en=1 for 1 cycle.
- R-type sub: opcode=000000, funct=100010, mem_ready=1 -> states 0,1,6,7,0. alu_load=01 in EXEC. reg_write=1, reg_dst=1 in ALUWB only.
- lw with 2 wait cycles: opcode=100011, mem_ready low 2 cycles in FETCH and in MEMRD -> FETCH 3 cycles with exactly one pc_en pulse; MEMRD 3 cycles; MEMWB reg_write=1, mem_to_reg=1; total 9 cycles.
- beq: opcode=000100 with zero=1 -> pc_en=1, pc_src=01, alu_load=01 in BRANCH. Repeat with zero=0 -> pc_en=0, return to FETCH.
- j and addi: opcode=000010 -> pc_en=1, pc_src=10, then FETCH (3 cycles). opcode=001000 -> ADDIEX alu_src_b=10, ADDIWB reg_write=1, reg_dst=0.
- Illegal: opcode=111111, then opcode=000000 with funct=101010 -> illegal=1 for exactly the DECODE cycle, next state FETCH, no write enable asserted.
